// File: rtl/dram_ctrl_pkg.sv
// Shared types and constants for the single-bank DRAM controller.
package dram_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PRE_WAIT,
        S_ACT,
        S_RCD_WAIT,
        S_CAS,
        S_RD_WAIT,
        S_GAP
    } state_t;

    // Default geometry and timing of the attached device.
    localparam int DEF_ROW_W   = 11;
    localparam int DEF_COL_W   = 10;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_T_RP    = 4;
    localparam int DEF_T_RCD   = 5;
    localparam int DEF_T_CCD   = 4;
    localparam int DEF_T_RD_TO = 32;

    // Width of the shared wait timer; must hold T_RD_TO - 1.
    localparam int TMR_W = 8;

    // WEn encodings that distinguish precharge from activate, and the idle value.
    localparam logic [3:0] WEN_PRE  = 4'b0000;
    localparam logic [3:0] WEN_ACT  = 4'b1111;
    localparam logic [3:0] WEN_IDLE = 4'b1111;

endpackage

// File: rtl/dram_ctrl_if.sv
// Front-port request/response bundle between the bus side and the controller.
interface dram_ctrl_if #(
    parameter int AW = 21
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [3:0]    req_wstrb;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    // Requester side.
    modport master (
        output req_valid, req_write, req_wstrb, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Controller side.
    modport slave (
        input  req_valid, req_write, req_wstrb, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dram_ctrl_timer.sv
// Loadable down-counter with a zero flag, shared by every wait in the controller.
module dram_ctrl_timer
    import dram_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_value,
    output logic [TMR_W-1:0] o_count,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;

    // Load on request, otherwise count down and park at zero.
    // NOTE: clocked state is always written with <=, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/dram_ctrl.sv
// Open-page controller: turns word requests into PRE/ACT/CAS sequences on
// the DRAM pins and returns read data or a timeout error.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int ROW_W   = DEF_ROW_W,
    parameter int COL_W   = DEF_COL_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_CCD   = DEF_T_CCD,
    parameter int T_RD_TO = DEF_T_RD_TO
) (
    input  logic              CK,
    input  logic              RST,
    dram_ctrl_if.slave        bus,
    output logic              CSn,
    output logic              RASn,
    output logic              CASn,
    output logic [3:0]        WEn,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       D,
    input  logic [31:0]       Q,
    input  logic              VALID
);

    // Wait loads: PRE_WAIT / RCD_WAIT last N-1 cycles and exit on zero, so load N-2.
    localparam logic [TMR_W-1:0] LD_RP  = TMR_W'(T_RP - 2);
    localparam logic [TMR_W-1:0] LD_RCD = TMR_W'(T_RCD - 2);
    // Loaded at CAS; reaches zero on the T_RD_TO-th cycle after the CAS.
    localparam logic [TMR_W-1:0] LD_CAS = TMR_W'(T_RD_TO - 1);
    // The same count measures time since CAS; at or below this value the next
    // CAS (one cycle after a handshake in IDLE) lands at least T_CCD after it.
    localparam logic [TMR_W-1:0] GAP_LIMIT = TMR_W'(T_RD_TO + 2 - T_CCD);

    state_t            r_state, w_state_nxt;

    logic              r_req_ready, r_rsp_valid, r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic              r_csn, r_rasn, r_casn;
    logic [3:0]        r_wen;
    logic [ADDR_W-1:0] r_a;
    logic [31:0]       r_d;

    logic              r_row_open;
    logic [ROW_W-1:0]  r_open_row;
    logic              r_write;
    logic [3:0]        r_wstrb;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [31:0]       r_wdata;

    logic              w_hs, w_zero_wr;
    logic [ROW_W-1:0]  w_in_row, w_cur_row;
    logic [COL_W-1:0]  w_in_col, w_cur_col;
    logic              w_cur_write;
    logic [3:0]        w_cur_wstrb;
    logic [31:0]       w_cur_wdata;

    logic              w_tmr_load, w_tmr_zero;
    logic [TMR_W-1:0]  w_tmr_value, w_tmr_count;

    logic              w_req_ready_d, w_rsp_valid_d, w_rsp_err_d;
    logic [31:0]       w_rsp_rdata_d;
    logic              w_rasn_d, w_casn_d;
    logic [3:0]        w_wen_d;
    logic [ADDR_W-1:0] w_a_d;
    logic [31:0]       w_d_d;

    assign w_hs      = bus.req_valid & r_req_ready;
    assign w_zero_wr = w_hs & bus.req_write & (bus.req_wstrb == 4'b0000);
    assign w_in_row  = bus.req_addr[ROW_W+COL_W-1:COL_W];
    assign w_in_col  = bus.req_addr[COL_W-1:0];

    // In IDLE the command for the next cycle comes straight from the bus;
    // afterwards it comes from the captured request.
    assign w_cur_row   = (r_state == S_IDLE) ? w_in_row       : r_row;
    assign w_cur_col   = (r_state == S_IDLE) ? w_in_col       : r_col;
    assign w_cur_write = (r_state == S_IDLE) ? bus.req_write  : r_write;
    assign w_cur_wstrb = (r_state == S_IDLE) ? bus.req_wstrb  : r_wstrb;
    assign w_cur_wdata = (r_state == S_IDLE) ? bus.req_wdata  : r_wdata;

    dram_ctrl_timer u_timer (
        .i_clk   (CK),
        .i_rst   (RST),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_count (w_tmr_count),
        .o_zero  (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and timer loads.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        case (r_state)
            S_IDLE: begin
                if (w_hs && !w_zero_wr) begin
                    if (!r_row_open)                  w_state_nxt = S_ACT;
                    else if (w_in_row == r_open_row)  w_state_nxt = S_CAS;
                    else                              w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                w_state_nxt = S_PRE_WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_value = LD_RP;
            end
            S_PRE_WAIT: if (w_tmr_zero) w_state_nxt = S_ACT;
            S_ACT: begin
                w_state_nxt = S_RCD_WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_value = LD_RCD;
            end
            S_RCD_WAIT: if (w_tmr_zero) w_state_nxt = S_CAS;
            S_CAS: begin
                w_state_nxt = r_write ? S_GAP : S_RD_WAIT;
                w_tmr_load  = 1'b1;
                w_tmr_value = LD_CAS;
            end
            S_RD_WAIT: if (VALID || w_tmr_zero) w_state_nxt = S_GAP;
            S_GAP:     if (w_tmr_count <= GAP_LIMIT) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered pins and response, decoded from the state being entered.
    always_comb begin
        w_rasn_d = 1'b1;
        w_casn_d = 1'b1;
        w_wen_d  = WEN_IDLE;
        w_a_d    = r_a;
        w_d_d    = r_d;
        case (w_state_nxt)
            S_PRE: begin
                w_rasn_d = 1'b0;
                w_wen_d  = WEN_PRE;
                w_a_d    = ADDR_W'(r_open_row);
            end
            S_ACT: begin
                w_rasn_d = 1'b0;
                w_wen_d  = WEN_ACT;
                w_a_d    = ADDR_W'(w_cur_row);
            end
            S_CAS: begin
                w_casn_d = 1'b0;
                w_a_d    = ADDR_W'(w_cur_col);
                if (w_cur_write) begin
                    w_wen_d = ~w_cur_wstrb;
                    w_d_d   = w_cur_wdata;
                end
            end
            default: ;
        endcase

        w_req_ready_d = (w_state_nxt == S_IDLE) && !w_zero_wr;
        w_rsp_valid_d = w_zero_wr
                      || ((r_state == S_CAS) && r_write)
                      || ((r_state == S_RD_WAIT) && (VALID || w_tmr_zero));
        w_rsp_rdata_d = ((r_state == S_RD_WAIT) && VALID) ? Q : 32'd0;
        w_rsp_err_d   = (r_state == S_RD_WAIT) && !VALID && w_tmr_zero;
    end

    // Registered DRAM pins and front-port outputs.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_csn       <= 1'b1;
            r_rasn      <= 1'b1;
            r_casn      <= 1'b1;
            r_wen       <= WEN_IDLE;
            r_a         <= '0;
            r_d         <= '0;
        end else begin
            r_req_ready <= w_req_ready_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_rsp_err   <= w_rsp_err_d;
            r_csn       <= 1'b0;
            r_rasn      <= w_rasn_d;
            r_casn      <= w_casn_d;
            r_wen       <= w_wen_d;
            r_a         <= w_a_d;
            r_d         <= w_d_d;
        end
    end

    // Request capture at the handshake and open-row tracking at activate.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_row_open <= 1'b0;
            r_open_row <= '0;
            r_write    <= 1'b0;
            r_wstrb    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_wdata    <= '0;
        end else begin
            if (w_hs) begin
                r_write <= bus.req_write;
                r_wstrb <= bus.req_wstrb;
                r_row   <= w_in_row;
                r_col   <= w_in_col;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == S_ACT) begin
                r_row_open <= 1'b1;
                r_open_row <= r_row;
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign CSn  = r_csn;
    assign RASn = r_rasn;
    assign CASn = r_casn;
    assign WEn  = r_wen;
    assign A    = r_a;
    assign D    = r_d;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed scoreboard bench for dram_ctrl with a small behavioural DRAM.
module tb_dram_ctrl;

    localparam int CL     = 1;
    localparam int K_PRE  = 0;
    localparam int K_ACT  = 1;
    localparam int K_RD   = 2;
    localparam int K_WR   = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [10:0] a;
        logic [3:0]  wen;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        CSn, RASn, CASn;
    logic [3:0]  WEn;
    logic [10:0] A;
    logic [31:0] D;
    logic [31:0] Q = '0;
    logic        VALID = 1'b0;

    dram_ctrl_if bus ();

    dram_ctrl dut (
        .CK    (CK),
        .RST   (RST),
        .bus   (bus),
        .CSn   (CSn),
        .RASn  (RASn),
        .CASn  (CASn),
        .WEn   (WEn),
        .A     (A),
        .D     (D),
        .Q     (Q),
        .VALID (VALID)
    );

    always #5 CK = ~CK;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   cas_log[$];

    // DRAM model state
    logic [31:0] mem [int];
    logic [10:0] m_row = '0;
    int          rd_due = -1;
    logic [31:0] rd_data = '0;
    bit          force_low = 1'b0;
    int          spur_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic exp_cmd(input int kind, input int c, input logic [10:0] a,
                           input logic [3:0] wen, input logic [31:0] d);
        cmd_t e;
        e.kind = kind; e.cyc = c; e.a = a; e.wen = wen; e.d = d;
        cmd_q.push_back(e);
    endtask

    task automatic exp_rsp(input int c, input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.cyc = c; e.rdata = rdata; e.err = err;
        rsp_q.push_back(e);
    endtask

    task automatic do_req(input logic wr, input logic [3:0] strb, input logic [10:0] row,
                          input logic [9:0] col, input logic [31:0] wd, output int t);
        int n;
        n = 0;
        @(negedge CK);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_wstrb = strb;
        bus.req_addr  = {row, col};
        bus.req_wdata = wd;
        while (!bus.req_ready && n < 200) begin
            @(negedge CK);
            n++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            $display("FAIL handshake: req_ready stayed 0 for %0d cycles, required 1", n);
            t = -1000;
        end else begin
            t = cyc;
        end
        @(posedge CK);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge CK);
            if (cmd_q.size() == 0 && rsp_q.size() == 0) break;
        end
        repeat (3) @(negedge CK);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        check({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
        check({tag, "_csn"},       64'(CSn),  64'd1);
        check({tag, "_rasn"},      64'(RASn), 64'd1);
        check({tag, "_casn"},      64'(CASn), 64'd1);
        check({tag, "_wen"},       64'(WEn),  64'hF);
        check({tag, "_a"},         64'(A),    64'd0);
        check({tag, "_d"},         64'(D),    64'd0);
    endtask

    // Cycle counter
    initial forever begin
        @(posedge CK);
        cyc++;
    end

    // Behavioural DRAM: tracks the open row, stores writes, answers reads after CL
    initial forever begin
        int key;
        logic [31:0] w;
        @(negedge CK);
        if (!RASn && WEn == 4'hF) m_row = A;
        if (!CASn) begin
            key = int'({m_row, A[9:0]});
            w = mem.exists(key) ? mem[key] : 32'd0;
            if (WEn != 4'hF) begin
                for (int b = 0; b < 4; b++) if (!WEn[b]) w[b*8 +: 8] = D[b*8 +: 8];
                mem[key] = w;
            end else begin
                rd_due  = cyc + CL;
                rd_data = w;
            end
        end
        if (cyc == rd_due && !force_low) begin
            VALID = 1'b1; Q = rd_data;
        end else if (cyc == spur_cyc) begin
            VALID = 1'b1; Q = 32'hDEAD_BEEF;
        end else begin
            VALID = 1'b0; Q = '0;
        end
    end

    // Command monitor: every strobe cycle must match the next expected command
    initial begin : cmd_mon
        logic [10:0] last_a;
        int kind;
        cmd_t e;
        last_a = '0;
        forever begin
            @(negedge CK);
            if (RST) begin
                last_a = '0;
            end else if (!RASn || !CASn) begin
                if (!RASn) kind = (WEn == 4'h0) ? K_PRE : K_ACT;
                else       kind = (WEn == 4'hF) ? K_RD : K_WR;
                if (!CASn) cas_log.push_back(cyc);
                if (cmd_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL cmd_unexpected: got kind %0d A=%0h at cycle %0d, required none", kind, A, cyc);
                end else begin
                    e = cmd_q.pop_front();
                    check("cmd_kind", 64'(kind), 64'(e.kind));
                    check("cmd_cycle", 64'(cyc), 64'(e.cyc));
                    check("cmd_a", 64'(A), 64'(e.a));
                    if (kind == K_RD || kind == K_WR) check("cmd_wen", 64'(WEn), 64'(e.wen));
                    if (kind == K_WR) check("cmd_d", 64'(D), 64'(e.d));
                end
                last_a = A;
            end else begin
                check("a_hold", 64'(A), 64'(last_a));
            end
        end
    end

    // Response monitor
    initial begin : rsp_mon
        rsp_t e;
        forever begin
            @(negedge CK);
            if (!RST && bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rsp_unexpected: got rsp_valid at cycle %0d, required none", cyc);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int t, t2, n0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_wstrb = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset values
        repeat (3) @(negedge CK);
        check_reset_pins("rst");
        #2 RST = 1'b0;
        @(negedge CK);
        check("post_rst_ready", 64'(bus.req_ready), 64'd1);
        check("post_rst_csn", 64'(CSn), 64'd0);

        // Write row 5 col 10 from reset: ACT, then CAS after tRCD
        do_req(1'b1, 4'hF, 11'd5, 10'd10, 32'd10, t);
        exp_cmd(K_ACT, t + 1, 11'd5, 4'hF, 32'd0);
        exp_cmd(K_WR,  t + 6, 11'd10, 4'h0, 32'd10);
        exp_rsp(t + 7, 32'd0, 1'b0);
        wait_drain();

        // Row-hit read of the same word
        do_req(1'b0, 4'h0, 11'd5, 10'd10, 32'd0, t);
        exp_cmd(K_RD, t + 1, 11'd10, 4'hF, 32'd0);
        exp_rsp(t + 1 + CL + 1, 32'd10, 1'b0);
        wait_drain();

        // Row miss: PRE old row, ACT after tRP, CAS after tRCD
        do_req(1'b1, 4'hF, 11'd8, 10'd11, 32'd13, t);
        exp_cmd(K_PRE, t + 1,  11'd5,  4'h0, 32'd0);
        exp_cmd(K_ACT, t + 5,  11'd8,  4'hF, 32'd0);
        exp_cmd(K_WR,  t + 10, 11'd11, 4'h0, 32'd13);
        exp_rsp(t + 11, 32'd0, 1'b0);
        wait_drain();

        // Two back-to-back hit reads
        n0 = cas_log.size();
        do_req(1'b0, 4'h0, 11'd8, 10'd11, 32'd0, t);
        exp_cmd(K_RD, t + 1, 11'd11, 4'hF, 32'd0);
        exp_rsp(t + 1 + CL + 1, 32'd13, 1'b0);
        do_req(1'b0, 4'h0, 11'd8, 10'd11, 32'd0, t2);
        exp_cmd(K_RD, t2 + 1, 11'd11, 4'hF, 32'd0);
        exp_rsp(t2 + 1 + CL + 1, 32'd13, 1'b0);
        wait_drain();
        if (cas_log.size() >= n0 + 2) check("cas_spacing", 64'(cas_log[n0+1] - cas_log[n0]), 64'd4);
        else check("cas_count", 64'(cas_log.size() - n0), 64'd2);

        // Partial write (bytes 0 and 2), then read the merged word
        do_req(1'b1, 4'b0101, 11'd8, 10'd11, 32'hAABB_CCDD, t);
        exp_cmd(K_WR, t + 1, 11'd11, 4'b1010, 32'hAABB_CCDD);
        exp_rsp(t + 2, 32'd0, 1'b0);
        wait_drain();
        do_req(1'b0, 4'h0, 11'd8, 10'd11, 32'd0, t);
        exp_cmd(K_RD, t + 1, 11'd11, 4'hF, 32'd0);
        exp_rsp(t + 1 + CL + 1, 32'h00BB_00DD, 1'b0);
        wait_drain();

        // Empty-strobe write: no DRAM command, response next cycle
        do_req(1'b1, 4'h0, 11'd8, 10'd0, 32'h1111_1111, t);
        exp_rsp(t + 1, 32'd0, 1'b0);
        check("zero_wr_ready_low", 64'(bus.req_ready), 64'd0);
        wait_drain();

        // Stray VALID while idle must not produce a response
        spur_cyc = cyc + 2;
        repeat (5) @(negedge CK);

        // Read timeout
        force_low = 1'b1;
        do_req(1'b0, 4'h0, 11'd8, 10'd11, 32'd0, t);
        exp_cmd(K_RD, t + 1, 11'd11, 4'hF, 32'd0);
        exp_rsp(t + 1 + 32 + 1, 32'd0, 1'b1);
        wait_drain();
        force_low = 1'b0;

        // Reset during RCD_WAIT of a row-miss write
        do_req(1'b1, 4'hF, 11'd3, 10'd1, 32'h5555_5555, t);
        exp_cmd(K_PRE, t + 1, 11'd8, 4'h0, 32'd0);
        exp_cmd(K_ACT, t + 5, 11'd3, 4'hF, 32'd0);
        for (int i = 0; i < 20 && cyc < t + 7; i++) @(negedge CK);
        #2 RST = 1'b1;
        #1 check_reset_pins("mid_rst");
        repeat (2) @(negedge CK);
        #2 RST = 1'b0;
        @(negedge CK);
        check("mid_rst_ready", 64'(bus.req_ready), 64'd1);
        repeat (10) @(negedge CK);

        // After reset the row is closed: ACT without PRE
        do_req(1'b1, 4'hF, 11'd3, 10'd1, 32'h0000_1234, t);
        exp_cmd(K_ACT, t + 1, 11'd3, 4'hF, 32'd0);
        exp_cmd(K_WR,  t + 6, 11'd1, 4'h0, 32'h0000_1234);
        exp_rsp(t + 7, 32'd0, 1'b0);
        wait_drain();
        do_req(1'b0, 4'h0, 11'd3, 10'd1, 32'd0, t);
        exp_cmd(K_RD, t + 1, 11'd1, 4'hF, 32'd0);
        exp_rsp(t + 1 + CL + 1, 32'h0000_1234, 1'b0);
        wait_drain();

        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
